// File: rtl/mem_write_checker.sv
// Watches a data-memory write port and checks that an expected list of
// (address, data) writes appears in order, with optional strictness and a cycle timeout.
module mem_write_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter bit          STRICT  = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             memwrite,
  input  logic [WIDTH-1:0]                 dataadr,
  input  logic [WIDTH-1:0]                 writedata,
  input  logic [DEPTH*WIDTH-1:0]           exp_adr,
  input  logic [DEPTH*WIDTH-1:0]           exp_data,
  input  logic [$clog2(DEPTH+1)-1:0]       exp_count,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             fail,
  output logic [1:0]                       fail_code,
  output logic [$clog2(DEPTH+1)-1:0]       match_idx,
  output logic [WIDTH-1:0]                 err_adr,
  output logic [WIDTH-1:0]                 err_data,
  output logic [$clog2(TIMEOUT+1)-1:0]     cycles
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISMATCH = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  state_t           state;
  logic [CW-1:0]    eff_count;
  logic [WIDTH-1:0] cur_adr;
  logic [WIDTH-1:0] cur_data;
  logic             hit;
  logic             last;
  logic             tmo;

  // Counts above DEPTH saturate so the entry select never runs off the table.
  assign eff_count = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;

  always_comb begin
    cur_adr  = '0;
    cur_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(match_idx) == i) begin
        cur_adr  = exp_adr[i*WIDTH +: WIDTH];
        cur_data = exp_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign hit  = memwrite && (dataadr == cur_adr) && (writedata == cur_data);
  assign last = ((match_idx + CW'(1)) == eff_count);
  assign tmo  = (cycles == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= CODE_NONE;
      match_idx <= '0;
      err_adr   <= '0;
      err_data  <= '0;
      cycles    <= '0;
    end else begin
      case (state)
        RUN: begin
          cycles <= cycles + TW'(1);
          if (hit) begin
            match_idx <= match_idx + CW'(1);
          end
          // A completing match outranks a timeout landing on the same edge.
          if (hit && last) begin
            state <= PASS;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (memwrite && !hit && STRICT) begin
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= CODE_MISMATCH;
            err_adr   <= dataadr;
            err_data  <= writedata;
          end else if (tmo) begin
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= CODE_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            match_idx <= '0;
            cycles    <= '0;
            fail_code <= CODE_NONE;
            err_adr   <= '0;
            err_data  <= '0;
            fail      <= 1'b0;
            if (eff_count == '0) begin
              state <= PASS;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  a_excl: assert property (@(posedge clk) disable iff (reset) !(pass && fail));
  a_busy: assert property (@(posedge clk) disable iff (reset) busy == (state == RUN));
  a_done: assert property (@(posedge clk) disable iff (reset)
                           done == ((state == PASS) || (state == FAIL)));

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: three checker instances (defaults, STRICT=0, TIMEOUT=16) share write stimulus.
module tb_mem_write_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_a, start_s, start_t;
  logic         memwrite;
  logic [31:0]  dataadr, writedata;
  logic [127:0] exp_adr, exp_data;
  logic [2:0]   exp_count;

  logic        busy_a, done_a, pass_a, fail_a;
  logic [1:0]  code_a;
  logic [2:0]  midx_a;
  logic [31:0] eadr_a, edat_a;
  logic [10:0] cyc_a;

  logic        busy_s, done_s, pass_s, fail_s;
  logic [1:0]  code_s;
  logic [2:0]  midx_s;
  logic [31:0] eadr_s, edat_s;
  logic [10:0] cyc_s;

  logic        busy_t, done_t, pass_t, fail_t;
  logic [1:0]  code_t;
  logic [2:0]  midx_t;
  logic [31:0] eadr_t, edat_t;
  logic [4:0]  cyc_t;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic        p;
    logic        f;
    logic [1:0]  c;
    int unsigned m;
    logic [31:0] a;
    logic [31:0] d;
    int unsigned cy;
  } exp_t;

  exp_t qa[$];
  exp_t qs[$];
  exp_t qt[$];

  always #5 clk = ~clk;

  mem_write_checker u_a (
    .clk(clk), .reset(reset), .start(start_a), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .exp_adr(exp_adr), .exp_data(exp_data),
    .exp_count(exp_count), .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .fail_code(code_a), .match_idx(midx_a), .err_adr(eadr_a), .err_data(edat_a), .cycles(cyc_a)
  );

  mem_write_checker #(.STRICT(1'b0)) u_s (
    .clk(clk), .reset(reset), .start(start_s), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .exp_adr(exp_adr), .exp_data(exp_data),
    .exp_count(exp_count), .busy(busy_s), .done(done_s), .pass(pass_s), .fail(fail_s),
    .fail_code(code_s), .match_idx(midx_s), .err_adr(eadr_s), .err_data(edat_s), .cycles(cyc_s)
  );

  mem_write_checker #(.TIMEOUT(16)) u_t (
    .clk(clk), .reset(reset), .start(start_t), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .exp_adr(exp_adr), .exp_data(exp_data),
    .exp_count(exp_count), .busy(busy_t), .done(done_t), .pass(pass_t), .fail(fail_t),
    .fail_code(code_t), .match_idx(midx_t), .err_adr(eadr_t), .err_data(edat_t), .cycles(cyc_t)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  task automatic check_evt(input exp_t e, input logic p, input logic f, input logic [1:0] c,
                           input logic [2:0] m, input logic [31:0] a, input logic [31:0] d,
                           input logic [10:0] cy);
    cmp({e.nm, ".pass"}, 64'(p), 64'(e.p));
    cmp({e.nm, ".fail"}, 64'(f), 64'(e.f));
    cmp({e.nm, ".fail_code"}, 64'(c), 64'(e.c));
    cmp({e.nm, ".match_idx"}, 64'(m), 64'(e.m));
    cmp({e.nm, ".err_adr"}, 64'(a), 64'(e.a));
    cmp({e.nm, ".err_data"}, 64'(d), 64'(e.d));
    cmp({e.nm, ".cycles"}, 64'(cy), 64'(e.cy));
  endtask

  task automatic chk_zero(input string nm, input logic b, input logic dn, input logic p,
                          input logic f, input logic [1:0] c, input logic [2:0] m,
                          input logic [31:0] a, input logic [31:0] d, input logic [10:0] cy);
    cmp({nm, ".busy"}, 64'(b), 64'd0);
    cmp({nm, ".done"}, 64'(dn), 64'd0);
    cmp({nm, ".pass"}, 64'(p), 64'd0);
    cmp({nm, ".fail"}, 64'(f), 64'd0);
    cmp({nm, ".fail_code"}, 64'(c), 64'd0);
    cmp({nm, ".match_idx"}, 64'(m), 64'd0);
    cmp({nm, ".err_adr"}, 64'(a), 64'd0);
    cmp({nm, ".err_data"}, 64'(d), 64'd0);
    cmp({nm, ".cycles"}, 64'(cy), 64'd0);
  endtask

  task automatic expect_done(input int id, input string nm, input logic p, input logic f,
                             input logic [1:0] c, input int unsigned m, input logic [31:0] a,
                             input logic [31:0] d, input int unsigned cy);
    exp_t e;
    e.nm = nm; e.p = p; e.f = f; e.c = c; e.m = m; e.a = a; e.d = d; e.cy = cy;
    case (id)
      0:       qa.push_back(e);
      1:       qs.push_back(e);
      default: qt.push_back(e);
    endcase
  endtask

  // Monitor: each rising done pops the next expected outcome for that instance.
  logic da_q = 1'b0, ds_q = 1'b0, dt_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1 && da_q !== 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL dut_a_done actual=unexpected expected=no_event");
      end else begin
        e = qa.pop_front();
        check_evt(e, pass_a, fail_a, code_a, midx_a, eadr_a, edat_a, cyc_a);
      end
    end
    if (done_s === 1'b1 && ds_q !== 1'b1) begin
      if (qs.size() == 0) begin
        total++; bad++;
        $display("FAIL dut_s_done actual=unexpected expected=no_event");
      end else begin
        e = qs.pop_front();
        check_evt(e, pass_s, fail_s, code_s, midx_s, eadr_s, edat_s, 11'(cyc_s));
      end
    end
    if (done_t === 1'b1 && dt_q !== 1'b1) begin
      if (qt.size() == 0) begin
        total++; bad++;
        $display("FAIL dut_t_done actual=unexpected expected=no_event");
      end else begin
        e = qt.pop_front();
        check_evt(e, pass_t, fail_t, code_t, midx_t, eadr_t, edat_t, 11'(cyc_t));
      end
    end
    da_q = done_a;
    ds_q = done_s;
    dt_q = done_t;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int id);
    case (id)
      0:       start_a = 1'b1;
      1:       start_s = 1'b1;
      default: start_t = 1'b1;
    endcase
    idle(1);
    start_a = 1'b0;
    start_s = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    idle(1);
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  task automatic set_tab(input logic [2:0] n,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] a2, input logic [31:0] d2,
                         input logic [31:0] a3, input logic [31:0] d3);
    exp_count = n;
    exp_adr   = {a3, a2, a1, a0};
    exp_data  = {d3, d2, d1, d0};
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_s = 1'b0; start_t = 1'b0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    exp_adr = '0; exp_data = '0; exp_count = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    chk_zero("reset_a", busy_a, done_a, pass_a, fail_a, code_a, midx_a, eadr_a, edat_a, cyc_a);
    chk_zero("reset_s", busy_s, done_s, pass_s, fail_s, code_s, midx_s, eadr_s, edat_s, cyc_s);
    chk_zero("reset_t", busy_t, done_t, pass_t, fail_t, code_t, midx_t, eadr_t, edat_t,
             11'(cyc_t));

    // Empty list passes straight from IDLE.
    set_tab(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_done(0, "count0", 1, 0, 2'b00, 0, 0, 0, 0);
    pulse(0); idle(2);

    set_tab(3'd1, 12, 32'h3F, 0, 0, 0, 0, 0, 0);
    expect_done(0, "single", 1, 0, 2'b00, 1, 0, 0, 1);
    pulse(0); wr(12, 32'h3F); idle(2);

    // Three writes with gaps; a stray start mid-run must be ignored.
    set_tab(3'd3, 0, 5, 4, 7, 12, 32'h3F, 0, 0);
    expect_done(0, "three_gaps", 1, 0, 2'b00, 3, 0, 0, 7);
    pulse(0); wr(0, 5); pulse(0); idle(1); wr(4, 7); idle(2); wr(12, 32'h3F); idle(2);

    set_tab(3'd1, 12, 32'h3F, 0, 0, 0, 0, 0, 0);
    expect_done(0, "data_mismatch", 0, 1, 2'b01, 0, 12, 32'h3E, 1);
    pulse(0); wr(12, 32'h3E); idle(2);

    expect_done(0, "adr_msb_mismatch", 0, 1, 2'b01, 0, 32'h8000_000C, 32'h3F, 1);
    pulse(0); wr(32'h8000_000C, 32'h3F); idle(2);

    set_tab(3'd3, 0, 5, 4, 7, 12, 32'h3F, 0, 0);
    expect_done(0, "second_mismatch", 0, 1, 2'b01, 1, 4, 8, 2);
    pulse(0); wr(0, 5); wr(4, 8); idle(2);

    // exp_count=7 saturates to DEPTH=4.
    set_tab(3'd7, 0, 5, 4, 7, 12, 32'h3F, 16, 9);
    expect_done(0, "overcount", 1, 0, 2'b00, 4, 0, 0, 4);
    pulse(0); wr(0, 5); wr(4, 7); wr(12, 32'h3F); wr(16, 9); idle(2);

    set_tab(3'd1, 12, 32'h3F, 0, 0, 0, 0, 0, 0);
    expect_done(1, "lenient", 1, 0, 2'b00, 1, 0, 0, 2);
    pulse(1); wr(8, 1); wr(12, 32'h3F); idle(2);

    expect_done(2, "timeout", 0, 1, 2'b10, 0, 0, 0, 16);
    pulse(2); idle(16); idle(2);

    expect_done(2, "last_cycle_pass", 1, 0, 2'b00, 1, 0, 0, 16);
    pulse(2); idle(15); wr(12, 32'h3F); idle(2);

    set_tab(3'd2, 0, 5, 4, 7, 0, 0, 0, 0);
    expect_done(2, "partial_timeout", 0, 1, 2'b10, 1, 0, 0, 16);
    pulse(2); wr(0, 5); idle(15); idle(2);

    set_tab(3'd3, 0, 5, 4, 7, 12, 32'h3F, 0, 0);
    pulse(0); wr(0, 5); wr(4, 7);
    cmp("pre_reset.match_idx", 64'(midx_a), 64'd2);
    cmp("pre_reset.busy", 64'(busy_a), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk_zero("async_reset", busy_a, done_a, pass_a, fail_a, code_a, midx_a, eadr_a, edat_a, cyc_a);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    chk_zero("post_reset_idle", busy_a, done_a, pass_a, fail_a, code_a, midx_a, eadr_a, edat_a,
             cyc_a);
    expect_done(0, "fresh_after_reset", 1, 0, 2'b00, 3, 0, 0, 3);
    pulse(0); wr(0, 5); wr(4, 7); wr(12, 32'h3F); idle(3);

    cmp("pending_a", 64'(qa.size()), 64'd0);
    cmp("pending_s", 64'(qs.size()), 64'd0);
    cmp("pending_t", 64'(qt.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- WIDTH, 32, address/data bus width
- DEPTH, 4, maximum number of expected writes
- TIMEOUT, 1024, RUN cycles allowed before timeout failure
- STRICT, 1, 1 = any non-matching write fails; 0 = non-matching writes are ignored
REQ-002 SHALL have ports, one per line: name  direction  width  meaning (clock and reset first):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  arm the checker (one-cycle pulse)
- memwrite  in  1  data-memory write strobe under observation
- dataadr  in  WIDTH  write address
- writedata  in  WIDTH  write data
- exp_adr  in  DEPTH*WIDTH  expected addresses; entry i = bits [i*WIDTH +: WIDTH]
- exp_data  in  DEPTH*WIDTH  expected data, same packing
- exp_count  in  $clog2(DEPTH+1)  number of active entries
- busy  out  1  checker in RUN
- done  out  1  checker in PASS or FAIL
- pass  out  1  all expected writes seen in order
- fail  out  1  mismatch or timeout
- fail_code  out  2  00 none, 01 mismatch, 10 timeout
- match_idx  out  $clog2(DEPTH+1)  count of entries matched so far
- err_adr  out  WIDTH  dataadr of the offending write
- err_data  out  WIDTH  writedata of the offending write
- cycles  out  $clog2(TIMEOUT+1)  RUN cycles elapsed

Function
REQ-003 SHALL implement FSM states IDLE, RUN, PASS, FAIL; all outputs SHALL be registered.
REQ-004 SHALL sample memwrite, dataadr and writedata on each rising clk edge; exp_* SHALL be held stable by the user while busy.
REQ-005 IDLE/PASS/FAIL + start=1 -> RUN next cycle; match_idx, cycles, fail_code, err_adr and err_data SHALL be cleared.
REQ-006 start while in RUN SHALL be ignored.
REQ-007 start with exp_count=0 SHALL go directly to PASS.
REQ-008 exp_count > DEPTH SHALL be treated as DEPTH.
REQ-009 In RUN, memwrite=1 with dataadr==exp_adr[match_idx] and writedata==exp_data[match_idx] is a match; match_idx SHALL increment by 1.
REQ-010 A match that brings match_idx to the effective exp_count SHALL move the FSM to PASS on that edge.
REQ-011 In RUN with STRICT=1, memwrite=1 without a match SHALL:
- move the FSM to FAIL with fail_code=01
- capture dataadr/writedata into err_adr/err_data
REQ-012 With STRICT=0, a non-matching write SHALL be ignored, and err_* SHALL keep its previous value.
REQ-013 cycles SHALL increment every RUN cycle.
REQ-014 If cycles reaches TIMEOUT-1 without completing, the FSM SHALL move to FAIL with fail_code=10, and err_* unchanged.
REQ-015 A completing match on the timeout cycle SHALL take priority, giving PASS.
REQ-016 memwrite=0 in RUN SHALL leave match_idx unchanged.
REQ-017 The comparison SHALL be full-width, with no masking.
REQ-018 PASS and FAIL SHALL be held until start or reset.
REQ-019 pass and fail SHALL never both be 1.
REQ-020 Outputs SHALL satisfy: busy=1 iff RUN; done=1 iff PASS or FAIL.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE and all outputs to 0, regardless of state.
REQ-022 After reset deasserts, the checker SHALL stay in IDLE until start.

Verification
REQ-023 Bench SHALL cover, one line each (defaults unless stated):
- exp_count=1, entry0=(12, 0x3F); start; write (12, 0x3F) -> pass=1 next edge, match_idx=1, fail_code=00.
- exp_count=3, entries (0, 5), (4, 7), (12, 0x3F); same three writes in order with idle gaps -> PASS after the third write.
- STRICT=1, entry0=(12, 0x3F); write (12, 0x3E) -> fail=1, fail_code=01, err_adr=12, err_data=0x3E.
- STRICT=0: writes (8, 1), then (12, 0x3F) -> pass=1.
- TIMEOUT=16, no writes -> fail_code=10 after 16 RUN cycles; completing write on the 16th cycle -> pass instead.
- reset asserted mid-RUN with match_idx=2 -> immediate IDLE, all outputs 0; start afterwards -> fresh check.
